// File: rtl/fx3_slfifo_resp_pkg.sv
// Shared constants and types for the FX3 slave-FIFO responder.
package fx3_slfifo_resp_pkg;

  localparam logic [1:0]  AD_U2F     = 2'b00;
  localparam logic [1:0]  AD_F2U     = 2'b11;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic              zlp;
    logic              last;
    logic [DATA_W-1:0] data;
  } f2u_entry_t;

  localparam int unsigned F2U_W = $bits(f2u_entry_t);

  typedef enum logic [1:0] {
    SOCK_IDLE = 2'd0,
    SOCK_U2F  = 2'd1,
    SOCK_F2U  = 2'd2
  } sock_t;

  // Unused addresses (01/10) and a deselected chip both map to idle.
  function automatic sock_t decode_sock(input logic cs_n, input logic [1:0] ad);
    sock_t s;
    s = SOCK_IDLE;
    if (!cs_n) begin
      if (ad == AD_U2F)      s = SOCK_U2F;
      else if (ad == AD_F2U) s = SOCK_F2U;
    end
    return s;
  endfunction

endpackage

// File: rtl/fx3_slfifo_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module slfifo_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic                   drop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full buffer still accepts a push when an entry leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fx3_slfifo_resp.sv
// FX3 slave-FIFO responder: U2F buffer read by the FPGA master, F2U buffer
// written by the master, both bridged to a host-side valid/ready interface.
module fx3_slfifo_resp
  import fx3_slfifo_resp_pkg::*;
#(
  parameter int unsigned DEPTH_U2F = 1024,
  parameter int unsigned DEPTH_F2U = 1024,
  parameter int unsigned WMARK     = 4
) (
  input  logic        SL_PCLK,
  input  logic        SL_RST_N,
  input  logic        SL_CS_N,
  input  logic        SL_RD_N,
  input  logic        SL_WR_N,
  input  logic        SL_OE_N,
  input  logic        SL_PKTEND_N,
  input  logic [1:0]  SL_AD,
  inout  wire  [31:0] SL_DT,
  output logic        SL_FLAGA,
  output logic        SL_FLAGB,
  output logic        SL_FLAGC,
  output logic        SL_FLAGD,
  input  logic        H_WR_VALID,
  output logic        H_WR_READY,
  input  logic [31:0] H_WR_DATA,
  output logic        H_RD_VALID,
  input  logic        H_RD_READY,
  output logic [31:0] H_RD_DATA,
  output logic        H_RD_LAST,
  output logic        H_RD_ZLP
);

  localparam int unsigned CU = $clog2(DEPTH_U2F) + 1;
  localparam int unsigned CF = $clog2(DEPTH_F2U) + 1;
  localparam logic [CU-1:0] U2F_AE = CU'(WMARK);
  localparam logic [CF-1:0] F2U_AF = CF'(DEPTH_F2U - WMARK);

  sock_t       sock;
  logic        rd_req;
  logic        wr_req;
  logic        zlp_req;
  logic        f2u_push;
  f2u_entry_t  f2u_in;
  f2u_entry_t  f2u_out;

  logic [31:0]   u2f_dout;
  logic          u2f_full;
  logic          u2f_empty;
  logic          u2f_drop;
  logic [CU-1:0] u2f_count;
  logic          f2u_full;
  logic          f2u_empty;
  logic          f2u_drop;
  logic [CF-1:0] f2u_count;

  logic [31:0]           pipe_data [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [31:0]           dt_q;
  logic                  dt_valid;
  logic                  dt_oe;
  logic                  overflow;

  assign sock     = decode_sock(SL_CS_N, SL_AD);
  assign rd_req   = (sock == SOCK_U2F) & ~SL_RD_N;
  assign wr_req   = (sock == SOCK_F2U) & ~SL_WR_N;
  assign zlp_req  = (sock == SOCK_F2U) & SL_WR_N & ~SL_PKTEND_N;
  assign f2u_push = wr_req | zlp_req;

  always_comb begin
    f2u_in = '0;
    if (wr_req) begin
      f2u_in.data = SL_DT;
      f2u_in.last = ~SL_PKTEND_N;
    end else if (zlp_req) begin
      f2u_in.zlp  = 1'b1;
      f2u_in.last = 1'b1;
    end
  end

  slfifo_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH_U2F)
  ) u_u2f (
    .clk       (SL_PCLK),
    .rst_n     (SL_RST_N),
    .push      (H_WR_VALID),
    .push_data (H_WR_DATA),
    .pop       (rd_req),
    .pop_data  (u2f_dout),
    .full      (u2f_full),
    .empty     (u2f_empty),
    .drop      (u2f_drop),
    .count     (u2f_count)
  );

  slfifo_sync_fifo #(
    .WIDTH (F2U_W),
    .DEPTH (DEPTH_F2U)
  ) u_f2u (
    .clk       (SL_PCLK),
    .rst_n     (SL_RST_N),
    .push      (f2u_push),
    .push_data (f2u_in),
    .pop       (H_RD_READY),
    .pop_data  (f2u_out),
    .full      (f2u_full),
    .empty     (f2u_empty),
    .drop      (f2u_drop),
    .count     (f2u_count)
  );

  assign H_WR_READY = ~u2f_full;
  assign H_RD_VALID = ~f2u_empty;
  assign H_RD_DATA  = f2u_out.data;
  assign H_RD_LAST  = f2u_out.last;
  assign H_RD_ZLP   = f2u_out.zlp;

  // Popped word lands in pipe stage 0 on the pop edge, reaches dt_q RD_LATENCY edges later.
  always_ff @(posedge SL_PCLK) begin
    if (!SL_RST_N) begin
      pipe_vld <= '0;
      dt_q     <= '0;
      dt_valid <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_req & ~u2f_empty;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      if (pipe_vld[RD_LATENCY-1]) begin
        dt_q     <= pipe_data[RD_LATENCY-1];
        dt_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge SL_PCLK) begin
    pipe_data[0] <= u2f_dout;
    for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  // Bus stays released after reset until a real word has reached the output.
  assign dt_oe = (sock == SOCK_U2F) & ~SL_OE_N & dt_valid;
  assign SL_DT = dt_oe ? dt_q : {32{1'bz}};

  always_ff @(posedge SL_PCLK) begin
    if (!SL_RST_N) begin
      SL_FLAGA <= 1'b1;
      SL_FLAGB <= 1'b1;
      SL_FLAGC <= 1'b0;
      SL_FLAGD <= 1'b0;
      overflow <= 1'b0;
    end else begin
      SL_FLAGA <= ~f2u_full;
      SL_FLAGB <= (f2u_count <= F2U_AF);
      SL_FLAGC <= ~u2f_empty;
      SL_FLAGD <= (u2f_count >= U2F_AE);
      if (f2u_drop | u2f_drop) overflow <= 1'b1;
    end
  end

endmodule
